// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED blinker.
// Holds the counter-width function so every level sizes the counter the same way.
package led_pkg;

  localparam int NUM_COUNT_DEFAULT = 25_000_000;

  // $clog2(1) is 0; a counter still needs at least one bit.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_blink_if.sv
// LED drive bundle between the blinker and whatever consumes the pin.
// The blinker is the master; pads or observers take the slave view.
interface led_blink_if;

  logic led;

  modport master (output led);
  modport slave  (input  led);

endinterface

// File: rtl/led_blink_tick_gen.sv
// Modulo-NUM_COUNT free-running counter with a one-cycle terminal-count pulse.
// Zero-latency tick from the registered count; no enable and no backpressure.
module tick_gen
  import led_pkg::*;
#(
  parameter  int NUM_COUNT = NUM_COUNT_DEFAULT,
  localparam int CNT_W     = clog2_min1(NUM_COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_d;

  // Wrap is an explicit compare so power-of-two counts behave like any other.
  always_comb begin
    tick    = (count_r == CNT_W'(NUM_COUNT - 1));
    count_d = count_r + CNT_W'(1);
    if (tick) begin
      count_d = '0;
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      count_r <= '0;
    end else begin
      count_r <= count_d;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/led_blink.sv
// LED blinker: toggles a registered LED on every terminal-count tick.
// LED period is 2*NUM_COUNT cycles; led is a pure flop output.
module led_blink
  import led_pkg::*;
#(
  parameter  int NUM_COUNT = NUM_COUNT_DEFAULT,
  localparam int CNT_W     = clog2_min1(NUM_COUNT)
) (
  input  logic clk,
  input  logic rst_n,
  output logic led
);

  if (NUM_COUNT < 1) begin : g_bad_num_count
    $error("led_blink: NUM_COUNT must be at least 1");
  end

  logic             tc;
  logic [CNT_W-1:0] count_r;
  logic             led_q;
  logic             led_d;

  tick_gen #(
    .NUM_COUNT (NUM_COUNT)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tc),
    .count (count_r)
  );

  always_comb begin
    led_d = led_q;
    if (tc) begin
      led_d = ~led_q;
    end
  end

  // Reset wins over a coincident tick so no toggle leaks through.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_blink.sv
// Bench for led_blink at NUM_COUNT = 5, 1 and 8 against an edge-count reference model.
// Expected state derives from edges since reset release: count = n % N, led = (n / N) % 2.
module tb_led_blink;

  logic clk = 1'b0;
  logic rst5 = 1'b1;
  logic rst1 = 1'b1;
  logic rst8 = 1'b1;

  led_blink_if if5 ();
  led_blink_if if1 ();
  led_blink_if if8 ();

  led_blink #(.NUM_COUNT(5)) dut5 (.clk(clk), .rst_n(rst5), .led(if5.led));
  led_blink #(.NUM_COUNT(1)) dut1 (.clk(clk), .rst_n(rst1), .led(if1.led));
  led_blink #(.NUM_COUNT(8)) dut8 (.clk(clk), .rst_n(rst8), .led(if8.led));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Edges since the last edge that sampled reset high.
  int n5 = 0;
  int n1 = 0;
  int n8 = 0;

  typedef struct {
    int rst;
    int exp_cnt;
    int exp_led;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive resets, take one edge, advance the model, sample 1 time unit later.
  task automatic step(input logic r5, input logic r1, input logic r8);
    rst5 = r5;
    rst1 = r1;
    rst8 = r8;
    @(posedge clk);
    n5 = r5 ? 0 : n5 + 1;
    n1 = r1 ? 0 : n1 + 1;
    n8 = r8 ? 0 : n8 + 1;
    #1;
  endtask

  task automatic check_all_vs_model(input string tag);
    check({tag, " cnt5"}, int'(dut5.count_r), n5 % 5);
    check({tag, " led5"}, int'(if5.led),      (n5 / 5) % 2);
    check({tag, " cnt1"}, int'(dut1.count_r), 0);
    check({tag, " led1"}, int'(if1.led),      n1 % 2);
    check({tag, " cnt8"}, int'(dut8.count_r), n8 % 8);
    check({tag, " led8"}, int'(if8.led),      (n8 / 8) % 2);
  endtask

  initial begin
    // Reset hold, reset landing on tc with led=0, free run, mid-run reset at led=1/cnt=2.
    vec_t tbl[22] = '{
      '{1, 0, 0}, '{1, 0, 0}, '{1, 0, 0},
      '{0, 1, 0}, '{0, 2, 0}, '{0, 3, 0}, '{0, 4, 0},
      '{1, 0, 0},
      '{0, 1, 0}, '{0, 2, 0}, '{0, 3, 0}, '{0, 4, 0},
      '{0, 0, 1}, '{0, 1, 1}, '{0, 2, 1},
      '{1, 0, 0},
      '{0, 1, 0}, '{0, 2, 0}, '{0, 3, 0}, '{0, 4, 0},
      '{0, 0, 1}, '{0, 1, 1}
    };
    int highs;
    int prev_led;

    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst[0], 1'b1, 1'b1);
      check($sformatf("tbl[%0d] cnt5", i), int'(dut5.count_r), tbl[i].exp_cnt);
      check($sformatf("tbl[%0d] led5", i), int'(if5.led),      tbl[i].exp_led);
    end

    // NUM_COUNT=1: counter pinned at 0, led alternates starting with 1.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b1);
      check($sformatf("n1 cnt[%0d]", i), int'(dut1.count_r), 0);
      check($sformatf("n1 led[%0d]", i), int'(if1.led), (i % 2 == 0) ? 1 : 0);
    end

    // NUM_COUNT=8: explicit wrap 7->0, led toggles on edges 8 and 16.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check($sformatf("n8 cnt@%0d", i), int'(dut8.count_r), i % 8);
      check($sformatf("n8 led@%0d", i), int'(if8.led), (i >= 8 && i < 16) ? 1 : 0);
    end

    // Long run, NUM_COUNT=5: exactly half the cycles high, transitions only at count 0.
    step(1'b1, 1'b1, 1'b1);
    highs = 0;
    prev_led = int'(if5.led);
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (if5.led) highs++;
      if (int'(if5.led) != prev_led) begin
        check($sformatf("long toggle@%0d cnt5", i), int'(dut5.count_r), 0);
      end
      prev_led = int'(if5.led);
    end
    check("long led5 high cycles", highs, 500);

    // Random independent resets on all three instances.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 39) == 0));
      check_all_vs_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
